mont_sched: RTL
===============

Name: mont_sched

Overview:
- Round-robin scheduler that shares one montgomery multiplier core among N_REQ requesters.
- Each requester sends an (A, B) operand pair over a valid/ready handshake. The block arbitrates, drives the core, and guards each operation with a watchdog timeout. It returns the result (or an error) on a per-requester response handshake.
- Sits between point-arithmetic sequencers and the single montgomery instance; modulus P is a shared configuration input.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 256, operand/result width
- TIMEOUT, 512, max cycles core_start may be held before the op is aborted (core latency ~273)
- TW, $clog2(TIMEOUT+1), watchdog counter width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mod_p  in  WIDTH  modulus; sampled into core_p at grant
- req_valid  in  N_REQ  request valid, one bit per requester
- req_ready  out  N_REQ  one-hot accept; at most one bit high
- req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- rsp_valid  out  N_REQ  one-hot response valid
- rsp_ready  in  N_REQ  response ready per requester
- rsp_m  out  WIDTH  result, shared bus, valid with rsp_valid
- rsp_err  out  1  1 = op aborted by watchdog, rsp_m = 0
- core_start  out  1  level start to montgomery core
- core_a, core_b, core_p  out  WIDTH each  registered core operands
- core_m  in  WIDTH  core result
- core_done  in  1  core completion (pulse or level; both supported)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE, rr pointer = 0, all outputs 0 (req_ready, rsp_valid, rsp_m, rsp_err, core_start, core_a/b/p, busy).
- States: IDLE, ISSUE, RESP, DRAIN.
- IDLE:
  - req_ready is combinational: one-hot winner among req_valid, searched from rr pointer upward with wrap.
  - All zero when no request is valid.
  - On the accept cycle: latch core_a/b from the winner slice, core_p from mod_p, grant id; clear the watchdog; go to ISSUE.
  - rr pointer = (winner+1) mod N_REQ. It wraps: a winner of N_REQ-1 makes the pointer 0.
- ISSUE:
  - core_start = 1 from the cycle after accept.
  - The watchdog increments each cycle.
  - If core_done = 1: capture core_m into rsp_m, rsp_err = 0, go to RESP.
  - Else if watchdog == TIMEOUT-1: rsp_m = 0, rsp_err = 1, go to RESP.
  - If core_done and timeout occur in the same cycle, done wins.
  - core_start drops on leaving ISSUE.
- RESP:
  - rsp_valid[grant] = 1. rsp_m and rsp_err are held stable until rsp_ready[grant] = 1.
  - rsp_ready of other requesters is ignored.
  - On handshake: clear rsp_valid, go to DRAIN.
- DRAIN:
  - Wait until core_done == 0, then go to IDLE. This covers a level-done core.
  - The earliest next accept is the cycle after re-entering IDLE.
- A requester may keep req_valid high through its own response. It competes again only in IDLE, behind other pending requesters (round-robin fairness).
- Throughput: one op outstanding. Minimum overhead per op is 4 cycles plus core latency.
- Async reset mid-operation: everything returns to reset values immediately and core_start drops. The in-flight op is lost and no response is issued.
- Results are registered. core_m is never passed combinationally to rsp_m.

Decomposition:
- Package mont_pkg: state enum (IDLE, ISSUE, RESP, DRAIN), WIDTH default constant, TIMEOUT default constant.
- One sub-module: rr_arbiter (N_REQ request vector + pointer -> one-hot grant + encoded index), purely combinational. Pointer update stays in mont_sched.

Test Plan:
- Single op:
  - Stimulus: bench core stub computes (A*B) mod P with 273-cycle latency and a 1-cycle done pulse; requester 0 sends A=5, B=7, mod_p=13.
  - Response: core_start rises 1 cycle after accept; rsp_valid[0] with rsp_m=9, rsp_err=0 at accept+275.
- Round-robin wrap:
  - Stimulus: all four requesters valid from reset.
  - Response: grant order 0,1,2,3,0; rr pointer wraps 3->0; no requester is granted twice before the others.
- Backpressure:
  - Stimulus: rsp_ready[2]=0 for 50 cycles after rsp_valid[2].
  - Response: rsp_m/rsp_err stable; no new accept and req_ready all 0 throughout; DRAIN then IDLE after ready.
- Watchdog:
  - Stimulus: stub never asserts done; TIMEOUT=512.
  - Response: rsp_valid with rsp_err=1, rsp_m=0 exactly 512 cycles after core_start rises; core_start then 0.
- Level done and collision:
  - Stimulus: stub holds done high until start drops, with done arriving on the same cycle as the timeout.
  - Response: rsp_err=0 and the correct result; the next accept waits for done low.
- Mid-op reset:
  - Stimulus: rst_n pulsed low 100 cycles into ISSUE.
  - Response: all outputs 0 asynchronously; no rsp_valid follows; the next request is served normally with rr pointer 0.

Source files
------------

// File: rtl/mont_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mont_pkg
// Description : Shared types and defaults for the montgomery scheduler slice.
//               Holds the scheduler state encoding, default sizing constants
//               and a helper that sizes index fields.
// Revision    : 1.0 - initial release
// ============================================================================
package mont_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int unsigned N_REQ_DFLT   = 4;
    localparam int unsigned WIDTH_DFLT   = 256;
    localparam int unsigned TIMEOUT_DFLT = 512;

    // Width of an index into n items; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mont_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches req_i starting at
//               ptr_i and moving upward with wrap; the first set bit wins.
// Ports       : req_i   - request vector, one bit per requester
//               ptr_i   - index where the search starts
//               grant_o - one-hot grant (all zero when no request)
//               idx_o   - encoded index of the winner
//               valid_o - high when any request won
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mont_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DFLT,
    parameter int unsigned IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);

    always_comb begin
        int unsigned cand;
        cand    = 0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            // Candidate position ptr+k folded back into 0..N_REQ-1.
            cand = {{(32-IW){1'b0}}, ptr_i} + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!valid_o && req_i[cand[IW-1:0]]) begin
                grant_o[cand[IW-1:0]] = 1'b1;
                idx_o                 = cand[IW-1:0];
                valid_o               = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mont_sched.sv
`default_nettype none
// ============================================================================
// Module      : mont_sched
// Description : Round-robin scheduler sharing one montgomery multiplier core
//               among N_REQ requesters, with a watchdog that aborts an
//               operation whose core never reports completion.
// Ports       : clk, rst_n           - clock, async active-low reset
//               mod_p                - shared modulus, captured at grant
//               req_valid/ready/a/b  - per-requester operand handshake
//               rsp_valid/ready      - per-requester response handshake
//               rsp_m, rsp_err       - shared registered result / abort flag
//               core_start/a/b/p     - drive to the montgomery core
//               core_m, core_done    - result and completion from the core
//               busy                 - high whenever an op is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module mont_sched
    import mont_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DFLT,
    parameter int unsigned WIDTH   = WIDTH_DFLT,
    parameter int unsigned TIMEOUT = TIMEOUT_DFLT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       mod_p,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_m,
    output logic                   rsp_err,
    output logic                   core_start,
    output logic [WIDTH-1:0]       core_a,
    output logic [WIDTH-1:0]       core_b,
    output logic [WIDTH-1:0]       core_p,
    input  logic [WIDTH-1:0]       core_m,
    input  logic                   core_done,
    output logic                   busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned IW = idx_w(N_REQ);

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      gnt_q, gnt_d;
    logic [TW-1:0]      wd_q, wd_d;
    logic [WIDTH-1:0]   core_a_q, core_a_d;
    logic [WIDTH-1:0]   core_b_q, core_b_d;
    logic [WIDTH-1:0]   core_p_q, core_p_d;
    logic [WIDTH-1:0]   rsp_m_q, rsp_m_d;
    logic               rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0]   arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            gnt_q     <= '0;
            wd_q      <= '0;
            core_a_q  <= '0;
            core_b_q  <= '0;
            core_p_q  <= '0;
            rsp_m_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            wd_q      <= wd_d;
            core_a_q  <= core_a_d;
            core_b_q  <= core_b_d;
            core_p_q  <= core_p_d;
            rsp_m_q   <= rsp_m_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        wd_d      = wd_q;
        core_a_d  = core_a_q;
        core_b_d  = core_b_q;
        core_p_d  = core_p_q;
        rsp_m_d   = rsp_m_q;
        rsp_err_d = rsp_err_q;
        req_ready = '0;
        rsp_valid = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    req_ready = arb_grant;
                    core_a_d  = req_a[arb_idx*WIDTH +: WIDTH];
                    core_b_d  = req_b[arb_idx*WIDTH +: WIDTH];
                    core_p_d  = mod_p;
                    gnt_d     = arb_idx;
                    wd_d      = '0;
                    // The winner moves to the back of the queue.
                    rr_d      = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                wd_d = wd_q + TW'(1);
                // Completion is checked first so a done arriving on the
                // timeout cycle still returns the real result.
                if (core_done) begin
                    rsp_m_d   = core_m;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (wd_q == TW'(TIMEOUT - 1)) begin
                    rsp_m_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A level-style done may still be high; never start a new
                // op until the core has released it.
                if (!core_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_start = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign core_p     = core_p_q;
    assign rsp_m      = rsp_m_q;
    assign rsp_err    = rsp_err_q;

endmodule : mont_sched
`default_nettype wire
